// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and default operand width for the bit-serial ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_NOT_A = 3'd4,
    OP_NOT_B = 3'd5,
    OP_RSVD6 = 3'd6,
    OP_RSVD7 = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice, purely combinational (zero latency, no handshake).
// Logic ops pass cin through so the serial carry flop is held across them.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] op,
  output logic       r,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    r     = 1'b0;
    cout  = cin;
    b_eff = (op == OP_SUB) ? ~b : b;
    case (op)
      OP_ADD, OP_SUB: begin
        r    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_NOT_A: r = ~a;
      OP_NOT_B: r = ~b;
      default:  r = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: accepts in IDLE, result valid WIDTH cycles after accept.
// Result and flags are held in DONE until out_ready; in_ready is low outside IDLE.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  op_e              op_q, op_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d, zero_q, zero_d, err_q, err_d;
  logic             s_r, s_cout;
  logic             last_bit;

  alu_bit_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .op   (op_q),
    .r    (s_r),
    .cout (s_cout)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_ADD;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid && in_ready) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    c_d     = c_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d   = a;
          b_d   = b;
          op_d  = op_e'(op);
          cnt_d = '0;
          c_d   = (op == OP_SUB);
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {s_r, res_q[WIDTH-1:1]};
        c_d   = s_cout;
        cnt_d = cnt_q + 1'b1;
        if (last_bit) begin
          // SUB runs as a + ~b + 1, so a borrow is the absence of carry-out
          carry_d = (op_q == OP_ADD) ? s_cout : (op_q == OP_SUB) ? ~s_cout : 1'b0;
          zero_d  = (res_d == '0);
          err_d   = (op_q == OP_RSVD6) || (op_q == OP_RSVD7);
        end
      end
      default: ;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl at WIDTH=8 against an arithmetic reference model.
module tb_alu_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       carry, zero, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .err       (err)
  );

  // {err, zero, carry, result[7:0]} from plain unsigned arithmetic
  function automatic logic [10:0] ref_model(input logic [7:0] ma, input logic [7:0] mb,
                                            input logic [2:0] mop);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    s = '0;
    c = 1'b0;
    case (mop)
      3'd0: begin s = {1'b0, ma} + {1'b0, mb}; r = s[7:0]; c = s[8]; end
      3'd1: begin r = ma - mb; c = (ma < mb); end
      3'd2: r = ma & mb;
      3'd3: r = ma | mb;
      3'd4: r = ~ma;
      3'd5: r = ~mb;
      default: r = 8'h00;
    endcase
    return {(mop >= 3'd6), (r == 8'h00), c, r};
  endfunction

  // Offers one operation and waits for out_valid; lat = cycles from accept edge to out_valid.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                       output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    a = ia; b = ib; op = iop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_txn(input string name, input logic [7:0] ia, input logic [7:0] ib,
                           input logic [2:0] iop);
    int lat;
    logic [10:0] exp_v, got_v;
    issue(ia, ib, iop, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected 8", name, lat);
    end
    @(negedge clk);
    exp_v = ref_model(ia, ib, iop);
    got_v = {err, zero, carry, result};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s a=%h b=%h op=%0d: got err/zero/carry/result=%b/%b/%b/%h, expected %b/%b/%b/%h",
               name, ia, ib, iop, got_v[10], got_v[9], got_v[8], got_v[7:0],
               exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
    end
    drain();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: in_ready=%b out_valid=%b, expected 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({in_ready, out_valid, result, carry, zero, err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h c/z/e=%b%b%b, expected all 0",
               in_ready, out_valid, result, carry, zero, err);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    check_txn("add_7f_01", 8'h7F, 8'h01, 3'd0);
    check_txn("add_ff_01", 8'hFF, 8'h01, 3'd0);
  endtask

  task automatic test_sub();
    check_txn("sub_05_07", 8'h05, 8'h07, 3'd1);
    check_txn("sub_07_07", 8'h07, 8'h07, 3'd1);
  endtask

  task automatic test_logic();
    for (int i = 2; i <= 5; i++) check_txn("logic_c3_5a", 8'hC3, 8'h5A, 3'(i));
  endtask

  task automatic test_backpressure();
    int lat;
    logic [10:0] exp_v;
    issue(8'h9A, 8'h77, 3'd0, lat);
    exp_v = ref_model(8'h9A, 8'h77, 3'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'h11; b = 8'h22; op = 3'd1; in_valid = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {err, zero, carry, result} !== exp_v) begin
        errors++;
        $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b c/z/e=%b%b%b result=%h, expected 1/0 %b%b%b %h",
                 i, out_valid, in_ready, carry, zero, err, result,
                 exp_v[8], exp_v[9], exp_v[10], exp_v[7:0]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure release: in_ready=%b out_valid=%b, expected 1/0", in_ready, out_valid);
    end
    // nothing was accepted while in DONE, so the engine must stay idle
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure ignored_offer: in_ready=%b, expected 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    check_txn("add_ff_01_pre", 8'hFF, 8'h01, 3'd0);
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; op = 3'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, result, carry, zero, err} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_run: in_ready=%b out_valid=%b result=%h c/z/e=%b%b%b, expected all 0",
               in_ready, out_valid, result, carry, zero, err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run release in_ready: got %b, expected 1", in_ready);
    end
    repeat (12) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_run stale result: out_valid=%b, expected 0", out_valid);
      end
    end
    check_txn("add_10_20", 8'h10, 8'h20, 3'd0);
  endtask

  task automatic test_reserved();
    check_txn("rsvd6", 8'hC3, 8'h5A, 3'd6);
    check_txn("rsvd7", 8'h01, 8'h02, 3'd7);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      check_txn("random", 8'($urandom), 8'($urandom), 3'($urandom_range(7, 0)));
    check_txn("add_ff_ff", 8'hFF, 8'hFF, 3'd0);
    check_txn("sub_00_ff", 8'h00, 8'hFF, 3'd1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_backpressure();
    test_reset_mid_run();
    test_reserved();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
